// File: rtl/pipe_issue_unit.sv
// ============================================================================
// pipe_issue_unit: FIFO-buffered issue front-end for pipe_ex2 with RAW bubbles.
// Optional hazard scoreboard enabled by macro PIPE_ISSUE_HAZARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_issue_unit #(
  parameter int         DEPTH        = 4,
  parameter int         HAZ_WIN      = 2,
  parameter logic [7:0] SCRATCH_ADDR = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_rs1,
  input  logic [3:0] in_rs2,
  input  logic [3:0] in_rd,
  input  logic [3:0] in_func,
  input  logic [7:0] in_addr,
  output logic [3:0] rs1,
  output logic [3:0] rs2,
  output logic [3:0] rd,
  output logic [3:0] func,
  output logic [7:0] addr,
  output logic       issue_valid,
  output logic       bubble,
  output logic [4:0] count,
  output logic [7:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] func;
    logic [7:0] addr;
  } instr_t;

  // Bubbles and idles share one encoding: ADD r0,r0 -> r0 stored to the scratch word.
  localparam instr_t c_idle = '{rs1: 4'd0, rs2: 4'd0, rd: 4'd0, func: 4'd0, addr: SCRATCH_ADDR};

  instr_t          fifo_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q, count_d;
  instr_t          out_q, out_d, head;
  logic            issue_valid_q, issue_valid_d;
  logic            bubble_d;
  logic            empty, push, pop, hazard;

  assign empty    = (count_q == 5'd0);
  assign in_ready = (count_q < 5'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !hazard;
  assign head     = fifo_q[rd_ptr_q];

  always_comb begin
    out_d         = c_idle;
    issue_valid_d = 1'b0;
    bubble_d      = 1'b0;
    if (!empty) begin
      if (hazard) begin
        bubble_d = 1'b1;
      end else begin
        out_d         = head;
        issue_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= 5'd0;
      out_q         <= c_idle;
      issue_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q       <= count_d;
      out_q         <= out_d;
      issue_valid_q <= issue_valid_d;
    end
  end

`ifdef PIPE_ISSUE_HAZARD_EN
  logic       bubble_q;
  logic [7:0] stall_q;

  if (HAZ_WIN > 0) begin : g_sb
    // Entry 0 holds the most recent issue slot.
    logic [HAZ_WIN-1:0] vld_q;
    logic [3:0]         sb_rd_q [HAZ_WIN];
    logic               hit;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        for (int i = 0; i < HAZ_WIN; i++) sb_rd_q[i] <= 4'd0;
      end else begin
        vld_q[0]   <= issue_valid_d;
        sb_rd_q[0] <= out_d.rd;
        for (int i = 1; i < HAZ_WIN; i++) begin
          vld_q[i]   <= vld_q[i-1];
          sb_rd_q[i] <= sb_rd_q[i-1];
        end
      end
    end

    always_comb begin
      hit = 1'b0;
      for (int i = 0; i < HAZ_WIN; i++) begin
        if (vld_q[i] && ((head.rs1 != 4'd0 && head.rs1 == sb_rd_q[i]) ||
                         (head.rs2 != 4'd0 && head.rs2 == sb_rd_q[i])))
          hit = 1'b1;
      end
    end

    assign hazard = !empty && hit;
  end else begin : g_nosb
    assign hazard = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= 1'b0;
      stall_q  <= 8'd0;
    end else begin
      bubble_q <= bubble_d;
      if (bubble_d && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
    end
  end

  assign bubble    = bubble_q;
  assign stall_cnt = stall_q;
`else
  logic unused_cfg;

  assign hazard     = 1'b0;
  assign bubble     = 1'b0;
  assign stall_cnt  = 8'd0;
  assign unused_cfg = bubble_d ^ (HAZ_WIN != 0);
`endif

  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign rd          = out_q.rd;
  assign func        = out_q.func;
  assign addr        = out_q.addr;
  assign issue_valid = issue_valid_q;
  assign count       = count_q;

endmodule

`default_nettype wire

// File: doc/pipe_issue_unit.md
# pipe_issue_unit

Instruction issue front-end for the two-operand register/memory pipeline (`pipe_ex2`). Buffers instructions offered by a producer over a valid/ready handshake in a small FIFO. Presents exactly one instruction field set per clock on the pipeline's `rs1/rs2/rd/func/addr` inputs. Enforces read-after-write spacing by inserting bubble instructions when the head instruction sources a register still in flight.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, 2..16.
- `HAZ_WIN`, 2: number of previous issue slots whose `rd` blocks a source read, 0..3.
- `SCRATCH_ADDR`, 255: memory address written by bubble instructions.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer offers an instruction.
- `in_ready`  out  1  FIFO can accept; `in_ready = (count < DEPTH)`, combinational from `count` only.
- `in_rs1`, `in_rs2`, `in_rd`, `in_func`  in  4 each  instruction fields.
- `in_addr`  in  8  destination memory address.
- `rs1`, `rs2`, `rd`, `func`  out  4 each  registered fields to the pipeline.
- `addr`  out  8  registered memory address to the pipeline.
- `issue_valid`  out  1  current output is a real instruction.
- `bubble`  out  1  current output is a hazard bubble.
- `count`  out  5  FIFO occupancy, 0..DEPTH.
- `stall_cnt`  out  8  bubbles inserted since reset, saturates at 255.

## Operation
- Push: at a rising edge with `in_valid && in_ready`, the fields are written at the tail. When `count == DEPTH`, `in_ready` is 0 even if a pop occurs in the same cycle. There is no pass-through.
- Bubble and idle encoding: `rs1 = rs2 = rd = 0`, `func = 0` (ADD), `addr = SCRATCH_ADDR`. Register r0 is reserved and held at 0 by software, so a bubble leaves architectural state unchanged apart from `mem[SCRATCH_ADDR]`.
- Scoreboard: a shift register of `HAZ_WIN` entries, each holding {valid, rd}. Every edge shifts in {`issue_valid_next`, `rd_next`}. Bubbles and idles enter as invalid.
- Hazard: asserted when the FIFO is non-empty and the head `rs1` or `rs2` equals the `rd` of any valid scoreboard entry. `rs == 0` never hazards.
- Per edge, one of three outcomes is selected:
  - FIFO empty: output the idle encoding with `issue_valid = 0` and `bubble = 0`.
  - Non-empty with hazard: output the bubble encoding with `bubble = 1`, increment `stall_cnt` (saturating). The head is kept.
  - Non-empty without hazard: pop the head into the outputs with `issue_valid = 1`.
- A push and a pop in the same edge update `count` by net 0.
- Pointers wrap modulo `DEPTH`.

## Timing
- All outputs except `in_ready` are registered.
- Minimum latency: an instruction accepted at edge t can appear on the outputs at edge t+1.
- Throughput: 1 instruction per cycle when there are no hazards.
- With `HAZ_WIN = 2`, a dependent instruction:
  - that immediately follows its producer gets 2 bubbles;
  - separated from its producer by one independent instruction gets 1 bubble;
  - separated by two or more gets none.
- Reset, asynchronous on `rst` high, takes effect immediately, including mid-operation:
  - outputs: idle encoding, `issue_valid = 0`, `bubble = 0`, `count = 0`, `stall_cnt = 0`;
  - internal state: scoreboard cleared, queued instructions discarded;
  - `in_ready = 1`.
- The first possible issue is at the first edge after `rst` is released with the FIFO non-empty.

## Configuration
- `PIPE_ISSUE_HAZARD_EN` defined: scoreboard and bubble insertion as described above.
- Not defined:
  - no scoreboard logic; hazard is tied to 0;
  - the head is issued every cycle the FIFO is non-empty;
  - `bubble` and `stall_cnt` are constant 0;
  - `HAZ_WIN` is ignored.

## Test plan
All scenarios use the defaults with the macro defined unless stated otherwise.
- Independent pair: push ADD(3,5→10,addr 125) and MUL(3,8→12,addr 126) on consecutive edges. Required: issued on consecutive cycles, `bubble` never 1, `stall_cnt = 0`.
- Adjacent RAW: ADD(3,5→10) then SUB(10,5→14). Required: ADD, then 2 bubble cycles (`rd = 0`, `addr = 255`), then SUB. `stall_cnt = 2`.
- Distance-2 RAW: ADD(→10), MUL(3,8→12), SUB(10,5→14). Required: exactly 1 bubble, between MUL and SUB. `stall_cnt = 1`.
- Full FIFO: hold `in_valid` high with a chain where each instruction reads the previous `rd`. Required: `count` reaches 4, `in_ready` drops to 0, and no entry is lost or duplicated. Check the issue order against the push order.
- Async reset with 3 entries queued, asserted mid-cycle. Required: `count = 0`, `in_ready = 1`, outputs at the idle encoding, and `issue_valid = 0` before the next edge. After release, no stale instruction is issued.
- Macro undefined, adjacent RAW scenario. Required: ADD and SUB issued on consecutive cycles, `bubble = 0`, `stall_cnt = 0`.
